// File: rtl/ngy_grid_scanout.sv
// ---------------------------------------------------------------------------
// ngy_grid_scanout
//   Scans the snake game's cell bitmap out to the Pocket video port. A clock
//   divider produces a one-cycle pixel enable, raster counters walk the
//   active/blanking regions, and each grid cell is drawn as an 8x8 pixel block.
//   The bitmap is copied into a shadow buffer once per frame at the start of
//   vertical blanking so game-side writes never tear a visible frame.
//
// Ports
//   clk_74a     in   sole clock (74.25 MHz)
//   reset_n     in   asynchronous active-low reset
//   grid_ram    in   [0:RAM_LENGTH-1] cell bitmap, bit = row*GRID_COLS+col
//   pix_ce      out  one-cycle pixel enable
//   video_rgb   out  24-bit {R,G,B} pixel color
//   video_de    out  active-video flag
//   video_hs    out  horizontal sync, active high
//   video_vs    out  vertical sync, active high
//   frame_start out  one-cycle pulse when a new snapshot is captured
// ---------------------------------------------------------------------------
module ngy_grid_scanout #(
  parameter int          GRID_ROWS  = 30,
  parameter int          GRID_COLS  = 40,
  parameter int          RAM_LENGTH = 1200,
  parameter int          PIX_DIV    = 12,
  parameter int          H_ACTIVE   = 320,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 32,
  parameter int          H_BP       = 32,
  parameter int          V_ACTIVE   = 240,
  parameter int          V_FP       = 4,
  parameter int          V_SYNC     = 4,
  parameter int          V_BP       = 10,
  parameter logic [23:0] FG_COLOR   = 24'h00FF00,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  input  logic [0:RAM_LENGTH-1] grid_ram,
  output logic                  pix_ce,
  output logic [23:0]           video_rgb,
  output logic                  video_de,
  output logic                  video_hs,
  output logic                  video_vs,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(PIX_DIV);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int SEL_W   = $clog2(RAM_LENGTH);
  localparam int IDX_W   = 11;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [IDX_W-1:0] COLS_L   = IDX_W'(GRID_COLS);
  localparam logic [IDX_W-1:0] ROWS_L   = IDX_W'(GRID_ROWS);

  logic [DIV_W-1:0]      div_q, div_d;
  logic [H_W-1:0]        h_cnt_q, h_cnt_d;
  logic [V_W-1:0]        v_cnt_q, v_cnt_d;
  logic [0:RAM_LENGTH-1] shadow_q, shadow_d;
  logic                  pix_ce_q, pix_ce_d;
  logic [23:0]           rgb_q, rgb_d;
  logic                  de_q, de_d;
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;
  logic                  frame_start_q, frame_start_d;

  logic                  tick;
  logic                  active;
  logic                  in_grid;
  logic                  snap;
  logic [IDX_W-1:0]      col, row, idx;
  logic [SEL_W-1:0]      sel;

  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    shadow_d      = shadow_q;
    rgb_d         = rgb_q;
    de_d          = de_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    pix_ce_d      = tick;

    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    col     = IDX_W'(h_cnt_q >> 3);
    row     = IDX_W'(v_cnt_q >> 3);
    in_grid = (col < COLS_L) && (row < ROWS_L);
    idx     = row * COLS_L + col;
    // Off-grid positions (beyond the bitmap) are forced to cell 0 and then
    // masked by in_grid, so the shadow is never addressed out of range.
    sel     = in_grid ? SEL_W'(idx) : '0;

    // Snapshot on the first pixel of vertical blanking.
    snap          = tick && (h_cnt_q == '0) && (v_cnt_q == V_ACT);
    frame_start_d = snap;

    if (tick) begin
      // Outputs come from the pre-advance counters, so they trail the
      // raster position by exactly one pixel.
      de_d = active;
      hs_d = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      vs_d = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      if (!active)
        rgb_d = 24'h000000;
      else if (in_grid && shadow_q[sel])
        rgb_d = FG_COLOR;
      else
        rgb_d = BG_COLOR;

      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
    end

    if (snap)
      shadow_d = grid_ram;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      shadow_q      <= '0;
      pix_ce_q      <= 1'b0;
      rgb_q         <= 24'h000000;
      de_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      shadow_q      <= shadow_d;
      pix_ce_q      <= pix_ce_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign video_rgb   = rgb_q;
  assign video_de    = de_q;
  assign video_hs    = hs_q;
  assign video_vs    = vs_q;
  assign frame_start = frame_start_q;

endmodule
